// File: rtl/ar_gearbox_pkg.sv
// Shared definitions for the FIFO unload gearbox: default widths, the
// lane-index type and a constant log2 helper used for parameter sizing.
package ar_gearbox_pkg;

    // Default FIFO word width and output lane width.
    localparam int DEF_IN_WIDTH  = 128;
    localparam int DEF_OUT_WIDTH = 32;
    localparam int DEF_RATIO     = DEF_IN_WIDTH / DEF_OUT_WIDTH;
    localparam int DEF_L2RATIO   = 2;

    // Lane index for the default geometry.
    typedef logic [DEF_L2RATIO-1:0] lane_idx_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ar_fifo_unload_gearbox.sv
// Dequeue-side reader for a show-ahead FIFO. Each wide FIFO word is parked
// in a holding register and emitted as ratio narrow lanes, least significant
// lane first, over a valid/ready stream. The next word is popped in the
// same cycle the last lane is accepted, so lanes flow with no bubbles.
module ar_fifo_unload_gearbox
    import ar_gearbox_pkg::*;
#(
    parameter int in_width  = DEF_IN_WIDTH,   // must be a multiple of out_width
    parameter int out_width = DEF_OUT_WIDTH,
    parameter int ratio     = in_width / out_width,  // must be >= 2
    parameter int l2ratio   = clog2(ratio)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CLR,
    input  logic                 EMPTY_N,
    input  logic [in_width-1:0]  D_IN,
    output logic                 DEQ,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [out_width-1:0] OUT_DATA,
    output logic                 OUT_FIRST,
    output logic                 OUT_LAST,
    output logic [31:0]          WORD_COUNT
);

    localparam logic [l2ratio-1:0] LANE_LAST = l2ratio'(ratio - 1);
    localparam logic [l2ratio-1:0] LANE_ZERO = '0;
    localparam logic [l2ratio-1:0] LANE_ONE  = l2ratio'(1);

    logic [in_width-1:0] hreg_r;
    logic                hvalid_r;
    logic [l2ratio-1:0]  lane_r;
    logic [31:0]         wcnt_r;

    logic                lane_last_s;
    logic                acc_s;
    logic                drain_s;
    logic                deq_s;

    // Handshake decode: lane acceptance, word drain and FIFO pop request.
    always_comb begin
        lane_last_s = 1'b0;
        acc_s       = 1'b0;
        drain_s     = 1'b0;
        deq_s       = 1'b0;
        lane_last_s = (lane_r == LANE_LAST);
        acc_s       = hvalid_r && OUT_READY;
        drain_s     = hvalid_r && lane_last_s && OUT_READY;
        // Pop when the holding register is free now or frees this cycle;
        // a clear suppresses the pop so no word is lost to the flush.
        if (EMPTY_N && !CLR) begin
            deq_s = !hvalid_r || drain_s;
        end else begin
            deq_s = 1'b0;
        end
    end

    // Occupancy, lane index and completed-word counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hvalid_r <= 1'b0;
            lane_r   <= LANE_ZERO;
            wcnt_r   <= 32'd0;
        end else if (CLR) begin
            hvalid_r <= 1'b0;
            lane_r   <= LANE_ZERO;
            wcnt_r   <= 32'd0;
        end else begin
            if (deq_s) begin
                hvalid_r <= 1'b1;
                lane_r   <= LANE_ZERO;
            end else if (drain_s) begin
                hvalid_r <= 1'b0;
                lane_r   <= LANE_ZERO;
            end else if (acc_s) begin
                lane_r   <= lane_r + LANE_ONE;
            end else begin
                lane_r   <= lane_r;
            end
            if (drain_s) begin
                wcnt_r <= wcnt_r + 32'd1;   // wraps naturally at 2^32
            end else begin
                wcnt_r <= wcnt_r;
            end
        end
    end

    // Holding register: data only, loaded on pop; contents are irrelevant
    // while hvalid_r is low, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (deq_s) begin
            hreg_r <= D_IN;
        end else begin
            hreg_r <= hreg_r;
        end
    end

    assign DEQ        = deq_s;
    assign OUT_VALID  = hvalid_r;
    assign OUT_DATA   = hreg_r[lane_r*out_width +: out_width];
    assign OUT_FIRST  = (lane_r == LANE_ZERO);
    assign OUT_LAST   = lane_last_s;
    assign WORD_COUNT = wcnt_r;

endmodule
